// File: rtl/serial_reader_pkg.sv
// Shared types and constants for the serial_reader block.
// Frame/block state encodings, data width and default baud divisor.
package serial_reader_pkg;

  localparam int SERIAL_DATA_BITS     = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    F_IDLE,
    F_START,
    F_DATA,
    F_PARITY,
    F_STOP,
    F_HOLD
  } frame_state_t;

  typedef enum logic [1:0] {
    B_OFF,
    B_ARMED,
    B_DONE
  } block_state_t;

  function automatic logic even_parity(
    input logic [SERIAL_DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/serial_reader_if.sv
// Controller-side bundle of the serial_reader block.
// master = Controller/line side, slave = serial_reader.
interface serial_reader_if #(
  parameter int BLOCK_BYTES = 8
);

  logic                       SeriaReadlEn;
  logic                       RxD;
  logic [8*BLOCK_BYTES-1:0]   Data;
  logic                       SerialReadRy;
  logic                       Err;

  modport master (
    output SeriaReadlEn,
    output RxD,
    input  Data,
    input  SerialReadRy,
    input  Err
  );

  modport slave (
    input  SeriaReadlEn,
    input  RxD,
    output Data,
    output SerialReadRy,
    output Err
  );

endinterface

// File: rtl/serial_reader_uart_rx_byte.sv
// UART byte receiver: synchronizer, frame FSM and bit counter.
// SERIAL_READER_PARITY_EN selects 8E1 framing instead of 8N1.
module uart_rx_byte
  import serial_reader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

`ifdef SERIAL_READER_PARITY_EN
  localparam frame_state_t AFTER_DATA = F_PARITY;
`else
  localparam frame_state_t AFTER_DATA = F_STOP;
`endif

  frame_state_t state_q;
  frame_state_t state_d;

  logic [2:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shreg_q;
  logic          par_err;

  logic rx_s;
  logic fall;
  logic tick;
  logic mid;

  // sync_q[2] is the previous rx_s, used for edge detection
  assign rx_s = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];
  assign tick = (cnt_q == LAST);
  assign mid  = (cnt_q == HALF);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], rxd};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= F_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = F_IDLE;
    end else begin
      unique case (state_q)
        F_IDLE:   if (fall) state_d = F_START;
        F_START:  if (mid) state_d = rx_s ? F_IDLE : F_DATA;
        F_DATA:   if (tick && bit_q == 3'd7) state_d = AFTER_DATA;
        F_PARITY: if (tick) state_d = F_STOP;
        F_STOP:   if (tick) state_d = rx_s ? F_IDLE : F_HOLD;
        F_HOLD:   if (rx_s) state_d = F_IDLE;
        default:  state_d = F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      if (state_d != state_q || tick ||
          state_q inside {F_IDLE, F_HOLD}) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == F_START) begin
        bit_q <= '0;
      end else if (state_q == F_DATA && tick) begin
        bit_q <= bit_q + 3'd1;
      end
      if (state_q == F_DATA && tick) begin
        shreg_q <= {rx_s, shreg_q[7:1]};
      end
    end
  end

`ifdef SERIAL_READER_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk) begin
    if (rst || state_q == F_START) begin
      par_err_q <= 1'b0;
    end else if (state_q == F_PARITY && tick) begin
      par_err_q <= rx_s ^ even_parity(shreg_q);
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (en && state_q == F_STOP && tick) begin
      byte_valid = rx_s & ~par_err;
      frame_err  = ~rx_s | par_err;
    end
  end

  assign byte_data = shreg_q;

endmodule

// File: rtl/serial_reader.sv
// Serial ingest: packs BLOCK_BYTES UART bytes into one block.
// SERIAL_READER_PARITY_EN (in uart_rx_byte) selects 8E1 frames.
module serial_reader
  import serial_reader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int BLOCK_BYTES  = 8
) (
  input  logic            Clk,
  input  logic            Rst,
  serial_reader_if.slave  bus
);

  localparam int W    = SERIAL_DATA_BITS * BLOCK_BYTES;
  localparam int CNTW = $clog2(BLOCK_BYTES + 1);

  block_state_t blk_q;
  block_state_t blk_d;

  logic [W-1:0]    data_q;
  logic [CNTW-1:0] cnt_q;
  logic            err_q;
  logic            ready;

  logic       rx_en;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;
  logic       commit;
  logic       last;

  // enable low in ARMED aborts on the same edge it is sampled
  assign rx_en  = (blk_q == B_ARMED) && bus.SeriaReadlEn;
  assign commit = rx_en && byte_valid;
  assign last   = (cnt_q == CNTW'(BLOCK_BYTES - 1));

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (Clk),
    .rst        (Rst),
    .en         (rx_en),
    .rxd        (bus.RxD),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      blk_q <= B_OFF;
    end else begin
      blk_q <= blk_d;
    end
  end

  always_comb begin
    blk_d = blk_q;
    unique case (blk_q)
      B_OFF: begin
        if (bus.SeriaReadlEn) blk_d = B_ARMED;
      end
      B_ARMED: begin
        if (!bus.SeriaReadlEn) blk_d = B_OFF;
        else if (commit && last) blk_d = B_DONE;
      end
      B_DONE: begin
        if (!bus.SeriaReadlEn) blk_d = B_OFF;
      end
      default: blk_d = B_OFF;
    endcase
  end

  always_comb begin
    ready = (blk_q == B_DONE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= rx_en && frame_err;
      if (!rx_en) begin
        cnt_q <= '0;
      end else if (commit) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
      // newest byte enters at the bottom, oldest drops off the top
      if (commit) begin
        data_q <= W'({data_q, byte_data});
      end
    end
  end

  assign bus.Data         = data_q;
  assign bus.SerialReadRy = ready;
  assign bus.Err          = err_q;

endmodule

// File: tb/tb_serial_reader.sv
// Randomized self-checking bench for serial_reader.
// Reference model: history of accepted bytes plus error count.
module tb_serial_reader;

  localparam int CPB = 16;
  localparam int BB  = 8;

`ifdef SERIAL_READER_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_reader_if #(.BLOCK_BYTES(BB)) bus ();

  serial_reader #(
    .CLKS_PER_BIT (CPB),
    .BLOCK_BYTES  (BB)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] hist[$];
  int  m_cnt   = 0;
  bit  m_on    = 0;
  bit  m_done  = 0;
  int  exp_err = 0;

  int err_run    = 0;
  int err_pulses = 0;
  int err_max    = 0;

  always @(negedge clk) begin
    if (bus.Err === 1'b1) begin
      err_run = err_run + 1;
      if (err_run == 1) err_pulses = err_pulses + 1;
      if (err_run > err_max) err_max = err_run;
    end else begin
      err_run = 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // last BB accepted bytes, first of them in the top byte
  function automatic logic [63:0] exp_data();
    logic [63:0] d = '0;
    int n = hist.size();
    int s = (n > BB) ? n - BB : 0;
    for (int i = s; i < n; i++) begin
      d = (d << 8) | 64'(hist[i]);
    end
    return d;
  endfunction

  task automatic send_bit(input logic b);
    bus.RxD = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input bit stop,
                            input bit flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (PAR_ON) send_bit((^b) ^ flip);
    send_bit(stop);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic m_send(input logic [7:0] b,
                        input bit stop,
                        input bit flip);
    send_frame(b, stop, flip);
    if (m_on && !m_done) begin
      if (stop && !(PAR_ON && flip)) begin
        hist.push_back(b);
        m_cnt++;
        if (m_cnt == BB) m_done = 1;
      end else begin
        exp_err++;
      end
    end
  endtask

  task automatic false_start(input int len);
    bus.RxD = 1'b0;
    repeat (len) @(negedge clk);
    bus.RxD = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic set_en();
    bus.SeriaReadlEn = 1'b1;
    m_on   = 1;
    m_cnt  = 0;
    m_done = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drop_en(input string tag);
    chk({tag, "_ry_pre"}, 64'(bus.SerialReadRy), 64'(m_done));
    bus.SeriaReadlEn = 1'b0;
    m_on   = 0;
    m_cnt  = 0;
    m_done = 0;
    @(negedge clk);
    chk({tag, "_ry_post"}, 64'(bus.SerialReadRy), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_block(input string tag);
    chk({tag, "_ry"}, 64'(bus.SerialReadRy), 64'(m_done));
    chk({tag, "_data"}, bus.Data, exp_data());
    chk({tag, "_err"}, 64'(err_pulses), 64'(exp_err));
  endtask

  logic [63:0] frozen;
  int abort_at;
  int r;

  initial begin
    rst = 1'b1;
    bus.SeriaReadlEn = 1'b0;
    bus.RxD = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", bus.Data, 64'd0);
    chk("rst_ry", 64'(bus.SerialReadRy), 64'd0);
    chk("rst_err", 64'(bus.Err), 64'd0);

    // directed block 0x01..0x08
    set_en();
    for (int i = 1; i <= 8; i++) begin
      m_send(8'(i), 1'b1, 1'b0);
      if (i == 7) chk("b1_ry_early", 64'(bus.SerialReadRy), 64'd0);
    end
    chk("b1_data_fixed", bus.Data, 64'h0102030405060708);
    check_block("b1");
    frozen = bus.Data;
    m_send(8'hFF, 1'b1, 1'b0);
    chk("done_frozen", bus.Data, frozen);
    chk("done_ry", 64'(bus.SerialReadRy), 64'd1);
    drop_en("b1");

    // false start, then a random block
    set_en();
    false_start(5);
    chk("fs_err", 64'(err_pulses), 64'(exp_err));
    chk("fs_ry", 64'(bus.SerialReadRy), 64'd0);
    for (int i = 0; i < 8; i++) begin
      m_send(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    end
    check_block("fs");
    drop_en("fs");

    // third byte has a bad stop bit
    set_en();
    for (int i = 0; i < 11; i++) begin
      m_send(8'($urandom_range(0, 255)), i != 2, 1'b0);
    end
    check_block("bad");
    chk("bad_err_width", 64'(err_max), 64'd1);
    drop_en("bad");

    // abort after four bytes, then a fresh block
    set_en();
    for (int i = 0; i < 4; i++) begin
      m_send(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    end
    check_block("ab");
    drop_en("ab");
    chk("ab_data_kept", bus.Data, exp_data());
    set_en();
    for (int i = 0; i < 8; i++) begin
      m_send(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    end
    check_block("ab2");
    drop_en("ab2");

    // reset in the middle of a frame
    set_en();
    m_send(8'h5A, 1'b1, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    bus.RxD = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    bus.RxD = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    m_cnt  = 0;
    m_done = 0;
    chk("mrst_data", bus.Data, 64'd0);
    chk("mrst_ry", 64'(bus.SerialReadRy), 64'd0);
    chk("mrst_err", 64'(bus.Err), 64'd0);
    repeat (2 * CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      m_send(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    end
    check_block("mrst");
    drop_en("mrst");

    if (PAR_ON) begin
      set_en();
      m_send(8'h03, 1'b1, 1'b1);
      check_block("par_bad");
      m_send(8'h03, 1'b1, 1'b0);
      check_block("par_good");
      drop_en("par");
    end

    // randomized blocks with faults and aborts
    for (int blk = 0; blk < 6; blk++) begin
      set_en();
      abort_at = ($urandom_range(0, 2) == 0) ?
                 int'($urandom_range(1, 7)) : 0;
      while (!m_done && !(abort_at != 0 && m_cnt == abort_at)) begin
        r = int'($urandom_range(0, 9));
        if (r == 0) begin
          false_start(int'($urandom_range(2, 6)));
        end else begin
          m_send(8'($urandom_range(0, 255)), r != 1,
                 PAR_ON && r == 2);
        end
      end
      if (m_done && $urandom_range(0, 1) == 1) begin
        m_send(8'($urandom_range(0, 255)), 1'b1, 1'b0);
      end
      check_block("rnd");
      drop_en("rnd");
    end

    chk("err_width_all", 64'(err_max), 64'(exp_err > 0 ? 1 : 0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
